// File: rtl/ttl_pkg.sv
// Shared 74-series conventions and terminal-count helper for the counter family.
// Also used by verification models so terminal detection has one definition.
package ttl_pkg;

    localparam logic DIR_UP        = 1'b1;
    localparam logic DIR_DOWN      = 1'b0;
    localparam logic ACTIVE_LOW_ON = 1'b0;

    // Terminal count: top of range when counting up, zero when counting down.
    function automatic logic is_terminal(
        input logic [63:0] q,
        input logic        ud,
        input logic [63:0] modulus
    );
        logic term_v;
        if (ud == DIR_UP) begin
            term_v = (q == (modulus - 64'd1));
        end else begin
            term_v = (q == 64'd0);
        end
        return term_v;
    endfunction

endpackage

// File: rtl/updown_counter_n_mod_step.sv
// Combinational modulo step: next count value and wrap indication for one edge.
// Compares against the terminal value before stepping, so no carry bit is ever needed.
module mod_step
    import ttl_pkg::*;
#(
    parameter int              WIDTH   = 8,
    parameter longint unsigned MODULUS = 64'd1 << WIDTH
) (
    input  logic [WIDTH-1:0] q,
    input  logic             ud,
    output logic [WIDTH-1:0] next_q,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MAX_Q  = WIDTH'(MODULUS - 64'd1);
    localparam logic [WIDTH-1:0] ONE_Q  = WIDTH'(64'd1);
    localparam logic [WIDTH-1:0] ZERO_Q = WIDTH'(64'd0);

    logic term_s;

    // Step up or down within 0..MODULUS-1, flagging the wrap-around edge.
    always_comb begin
        term_s = is_terminal(64'(q), ud, MODULUS);
        next_q = q;
        wrap   = 1'b0;
        if (ud == DIR_UP) begin
            if (term_s) begin
                next_q = ZERO_Q;
                wrap   = 1'b1;
            end else begin
                next_q = q + ONE_Q;
                wrap   = 1'b0;
            end
        end else begin
            if (term_s) begin
                next_q = MAX_Q;
                wrap   = 1'b1;
            end else begin
                next_q = q - ONE_Q;
                wrap   = 1'b0;
            end
        end
    end

endmodule

// File: rtl/updown_counter_n.sv
// Parametrised modulo up/down counter with 74x169-style active-low controls,
// range-checked parallel load, sticky wrap flag and ent-gated ripple carry.
module updown_counter_n
    import ttl_pkg::*;
#(
    parameter int              WIDTH   = 8,
    parameter longint unsigned MODULUS = 64'd1 << WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             ud,
    input  logic             ent,
    input  logic             enp,
    input  logic             clear_wrap,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             rco,
    output logic             wrapped,
    output logic             load_err
);

    if ((WIDTH < 32'sd1) || (WIDTH > 32'sd63)) begin : g_width_chk
        $error("updown_counter_n: WIDTH must be in 1..63");
    end
    if ((MODULUS < 64'd2) || (MODULUS > (64'd1 << WIDTH))) begin : g_modulus_chk
        $error("updown_counter_n: MODULUS must be in 2..2**WIDTH");
    end

    logic [WIDTH-1:0] q_r;
    logic             wrapped_r;
    logic             load_err_r;
    logic [WIDTH-1:0] next_q_s;
    logic             wrap_s;
    logic             count_s;
    logic             load_ok_s;

    mod_step #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS)
    ) u_step (
        .q      (q_r),
        .ud     (ud),
        .next_q (next_q_s),
        .wrap   (wrap_s)
    );

    // Decode count enable and load range check.
    always_comb begin
        count_s   = (ent == ACTIVE_LOW_ON) && (enp == ACTIVE_LOW_ON) && (load != ACTIVE_LOW_ON);
        load_ok_s = (64'(d) < MODULUS);
    end

    // Count state: reset > load > count > hold; wrap set beats clear_wrap.
    always_ff @(posedge clock) begin
        if (reset) begin
            q_r        <= WIDTH'(64'd0);
            wrapped_r  <= 1'b0;
            load_err_r <= 1'b0;
        end else if (load == ACTIVE_LOW_ON) begin
            wrapped_r <= 1'b0;
            if (load_ok_s) begin
                q_r        <= d;
                load_err_r <= 1'b0;
            end else begin
                q_r        <= WIDTH'(64'd0);
                load_err_r <= 1'b1;
            end
        end else begin
            load_err_r <= 1'b0;
            if (count_s) begin
                q_r <= next_q_s;
            end else begin
                q_r <= q_r;
            end
            if (count_s && wrap_s) begin
                wrapped_r <= 1'b1;
            end else if (clear_wrap) begin
                wrapped_r <= 1'b0;
            end else begin
                wrapped_r <= wrapped_r;
            end
        end
    end

    // Ripple carry is gated by ent (not enp) so cascaded stages only see their own carry.
    always_comb begin
        rco = ~((ent == ACTIVE_LOW_ON) && is_terminal(64'(q_r), ud, MODULUS));
    end

    assign q        = q_r;
    assign wrapped  = wrapped_r;
    assign load_err = load_err_r;

endmodule

// File: tb/tb_updown_counter_n.sv
// Scoreboard bench for updown_counter_n: single decade counter plus a two-digit BCD cascade.
module tb_updown_counter_n;

    typedef struct {
        logic [3:0] q;
        logic       w;
        logic       e;
        logic       r;
    } exp_t;

    typedef struct {
        logic [3:0] lq;
        logic [3:0] hq;
        logic       lw;
        logic       hw;
    } cexp_t;

    logic       clock = 1'b0;
    logic       reset, load, ud, ent, enp, clear_wrap;
    logic [3:0] d;
    logic [3:0] q;
    logic       rco, wrapped, load_err;

    logic       c_reset, c_enp;
    logic [3:0] lo_q, hi_q;
    logic       lo_rco, hi_rco, lo_w, hi_w, lo_e, hi_e;

    int total = 0;
    int bad   = 0;

    exp_t  sb[$];
    cexp_t csb[$];
    logic [3:0] mq;
    logic       mw, me;

    always #5 clock = ~clock;

    updown_counter_n #(.WIDTH(4), .MODULUS(10)) dut (
        .clock(clock), .reset(reset), .load(load), .ud(ud), .ent(ent), .enp(enp),
        .clear_wrap(clear_wrap), .d(d), .q(q), .rco(rco), .wrapped(wrapped), .load_err(load_err)
    );

    updown_counter_n #(.WIDTH(4), .MODULUS(10)) u_lo (
        .clock(clock), .reset(c_reset), .load(1'b1), .ud(1'b1), .ent(1'b0), .enp(c_enp),
        .clear_wrap(1'b0), .d(4'd0), .q(lo_q), .rco(lo_rco), .wrapped(lo_w), .load_err(lo_e)
    );

    updown_counter_n #(.WIDTH(4), .MODULUS(10)) u_hi (
        .clock(clock), .reset(c_reset), .load(1'b1), .ud(1'b1), .ent(lo_rco), .enp(c_enp),
        .clear_wrap(1'b0), .d(4'd0), .q(hi_q), .rco(hi_rco), .wrapped(hi_w), .load_err(hi_e)
    );

    // Advance the reference model for the current inputs, queue the expectation, clock once.
    task automatic tick();
        exp_t e;
        logic wev;
        wev = 1'b0;
        if (reset) begin
            mq = 4'd0; mw = 1'b0; me = 1'b0;
        end else if (!load) begin
            mw = 1'b0;
            if (d < 4'd10) begin mq = d; me = 1'b0; end
            else begin mq = 4'd0; me = 1'b1; end
        end else begin
            me = 1'b0;
            if (!ent && !enp) begin
                if (ud) begin
                    if (mq == 4'd9) begin mq = 4'd0; wev = 1'b1; end
                    else mq = mq + 4'd1;
                end else begin
                    if (mq == 4'd0) begin mq = 4'd9; wev = 1'b1; end
                    else mq = mq - 4'd1;
                end
            end
            if (wev) mw = 1'b1;
            else if (clear_wrap) mw = 1'b0;
        end
        e.q = mq; e.w = mw; e.e = me;
        e.r = !(!ent && (ud ? (mq == 4'd9) : (mq == 4'd0)));
        sb.push_back(e);
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        reset = 1'b1; load = 1'b1; ud = 1'b1; ent = 1'b1; enp = 1'b1; clear_wrap = 1'b0; d = 4'd0;
        tick();
        e = sb.pop_front();
        total += 4;
        if (q !== e.q) begin bad++; $display("FAIL reset_q got=%0d want=%0d", q, e.q); end
        if (wrapped !== e.w) begin bad++; $display("FAIL reset_wrapped got=%b want=%b", wrapped, e.w); end
        if (load_err !== e.e) begin bad++; $display("FAIL reset_load_err got=%b want=%b", load_err, e.e); end
        if (rco !== 1'b1) begin bad++; $display("FAIL reset_rco got=%b want=1", rco); end
    endtask

    task automatic test_count_up();
        exp_t e;
        reset = 1'b0; ent = 1'b0; enp = 1'b0; ud = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            e = sb.pop_front();
            total += 3;
            if (q !== e.q) begin bad++; $display("FAIL up_q[%0d] got=%0d want=%0d", i, q, e.q); end
            if (wrapped !== e.w) begin bad++; $display("FAIL up_wrapped[%0d] got=%b want=%b", i, wrapped, e.w); end
            if (rco !== e.r) begin bad++; $display("FAIL up_rco[%0d] got=%b want=%b", i, rco, e.r); end
        end
    endtask

    task automatic test_count_down();
        exp_t e;
        load = 1'b0; d = 4'd3;
        tick();
        e = sb.pop_front();
        total += 2;
        if (q !== e.q) begin bad++; $display("FAIL load3_q got=%0d want=%0d", q, e.q); end
        if (wrapped !== e.w) begin bad++; $display("FAIL load3_wrapped got=%b want=%b", wrapped, e.w); end
        load = 1'b0; load = 1'b1; ud = 1'b0;
        for (int i = 0; i < 5; i++) begin
            clear_wrap = (mq == 4'd0);
            tick();
            e = sb.pop_front();
            total += 3;
            if (q !== e.q) begin bad++; $display("FAIL down_q[%0d] got=%0d want=%0d", i, q, e.q); end
            if (wrapped !== e.w) begin bad++; $display("FAIL down_wrapped[%0d] got=%b want=%b", i, wrapped, e.w); end
            if (rco !== e.r) begin bad++; $display("FAIL down_rco[%0d] got=%b want=%b", i, rco, e.r); end
        end
        clear_wrap = 1'b1; ent = 1'b1;
        tick();
        e = sb.pop_front();
        total += 2;
        if (wrapped !== e.w) begin bad++; $display("FAIL clear_wrap got=%b want=%b", wrapped, e.w); end
        if (q !== e.q) begin bad++; $display("FAIL clear_hold_q got=%0d want=%0d", q, e.q); end
        clear_wrap = 1'b0; ent = 1'b0;
    endtask

    task automatic test_bad_load();
        exp_t e;
        ud = 1'b0; load = 1'b0; d = 4'd0;
        tick();
        void'(sb.pop_front());
        load = 1'b1;
        tick();
        e = sb.pop_front();
        total += 1;
        if (wrapped !== e.w) begin bad++; $display("FAIL pre_bad_wrapped got=%b want=%b", wrapped, e.w); end
        for (int i = 0; i < 3; i++) begin
            load = (i == 2); d = (i == 0) ? 4'd12 : 4'd15; ent = (i == 2);
            tick();
            e = sb.pop_front();
            total += 3;
            if (q !== e.q) begin bad++; $display("FAIL badload_q[%0d] got=%0d want=%0d", i, q, e.q); end
            if (load_err !== e.e) begin bad++; $display("FAIL badload_err[%0d] got=%b want=%b", i, load_err, e.e); end
            if (wrapped !== e.w) begin bad++; $display("FAIL badload_wrapped[%0d] got=%b want=%b", i, wrapped, e.w); end
        end
        ent = 1'b0;
    endtask

    task automatic test_priority();
        exp_t e;
        reset = 1'b1; load = 1'b0; d = 4'd5; ent = 1'b0; enp = 1'b0; ud = 1'b1;
        tick();
        e = sb.pop_front();
        total += 1;
        if (q !== e.q) begin bad++; $display("FAIL prio_reset_q got=%0d want=%0d", q, e.q); end
        reset = 1'b0;
        tick();
        e = sb.pop_front();
        total += 1;
        if (q !== e.q) begin bad++; $display("FAIL prio_load_q got=%0d want=%0d", q, e.q); end
        load = 1'b1;
    endtask

    task automatic test_enables();
        exp_t e;
        load = 1'b0; d = 4'd9; ud = 1'b1;
        tick();
        void'(sb.pop_front());
        load = 1'b1;
        for (int i = 0; i < 3; i++) begin
            enp = (i == 0); ent = (i != 0); ud = (i != 2);
            tick();
            e = sb.pop_front();
            total += 2;
            if (q !== e.q) begin bad++; $display("FAIL en_q[%0d] got=%0d want=%0d", i, q, e.q); end
            if (rco !== e.r) begin bad++; $display("FAIL en_rco[%0d] got=%b want=%b", i, rco, e.r); end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        for (int i = 0; i < 60; i++) begin
            reset      = ($urandom_range(0, 19) == 0);
            load       = ($urandom_range(0, 5) != 0);
            d          = 4'($urandom_range(0, 15));
            ud         = 1'($urandom_range(0, 1));
            ent        = ($urandom_range(0, 4) == 0);
            enp        = ($urandom_range(0, 4) == 0);
            clear_wrap = ($urandom_range(0, 3) == 0);
            tick();
            e = sb.pop_front();
            total += 4;
            if (q !== e.q) begin bad++; $display("FAIL rnd_q[%0d] got=%0d want=%0d", i, q, e.q); end
            if (wrapped !== e.w) begin bad++; $display("FAIL rnd_wrapped[%0d] got=%b want=%b", i, wrapped, e.w); end
            if (load_err !== e.e) begin bad++; $display("FAIL rnd_load_err[%0d] got=%b want=%b", i, load_err, e.e); end
            if (rco !== e.r) begin bad++; $display("FAIL rnd_rco[%0d] got=%b want=%b", i, rco, e.r); end
        end
        reset = 1'b0; load = 1'b1; clear_wrap = 1'b0;
    endtask

    task automatic test_cascade();
        cexp_t c, got;
        logic [3:0] lq, hq;
        logic       lw, hw, carry;
        c_reset = 1'b1; c_enp = 1'b0;
        lq = 4'd0; hq = 4'd0; lw = 1'b0; hw = 1'b0;
        @(posedge clock);
        #1;
        c_reset = 1'b0;
        for (int i = 1; i <= 100; i++) begin
            carry = (lq == 4'd9);
            if (carry) begin lq = 4'd0; lw = 1'b1; end else lq = lq + 4'd1;
            if (carry) begin
                if (hq == 4'd9) begin hq = 4'd0; hw = 1'b1; end else hq = hq + 4'd1;
            end
            c.lq = lq; c.hq = hq; c.lw = lw; c.hw = hw;
            csb.push_back(c);
            @(posedge clock);
            #1;
            got = csb.pop_front();
            total += 3;
            if (lo_q !== got.lq) begin bad++; $display("FAIL bcd_lo[%0d] got=%0d want=%0d", i, lo_q, got.lq); end
            if (hi_q !== got.hq) begin bad++; $display("FAIL bcd_hi[%0d] got=%0d want=%0d", i, hi_q, got.hq); end
            if (hi_w !== got.hw) begin bad++; $display("FAIL bcd_hi_wrapped[%0d] got=%b want=%b", i, hi_w, got.hw); end
        end
        total += 2;
        if ({hi_q, lo_q} !== 8'h00) begin bad++; $display("FAIL bcd_final got=%h want=00", {hi_q, lo_q}); end
        if (lo_w !== 1'b1) begin bad++; $display("FAIL bcd_lo_wrapped got=%b want=1", lo_w); end
    endtask

    initial begin
        c_reset = 1'b1; c_enp = 1'b1;
        mq = 4'd0; mw = 1'b0; me = 1'b0;
        test_reset();
        test_count_up();
        test_count_down();
        test_bad_load();
        test_priority();
        test_enables();
        test_back_to_back();
        test_cascade();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
